ad_ddr_wr_sched: RTL and testbench
==================================

AD_DDR_WR_SCHED -- requirements
Module: ad_ddr_wr_sched

Interface
REQ-001 The block SHALL have parameter BURST_LEN, default 16; words per DDR burst, power of two, 2..64.
REQ-002 The block SHALL have parameter ADDR_W, default 25; DDR word-address width.
REQ-003 The block SHALL have parameter BASE_ADDR, default 0; first word address of the capture region, BURST_LEN-aligned.
REQ-004 The block SHALL have parameter REGION_WORDS, default 2^20; capture region size in words, a multiple of BURST_LEN.
REQ-005 Port ddr_clk  in  1: the single clock, which also drives the FIFO read side.
REQ-006 Port reset_ayn  in  1: asynchronous, active-high reset.
REQ-007 Port cap_en  in  1: level; 1 = capture running, 0 = stop and flush.
REQ-008 Port fifo_usedw  in  10: read-side word count of the sample FIFO.
REQ-009 Port fifo_empty  in  1: sample FIFO is empty.
REQ-010 Port fifo_q  in  32: show-ahead FIFO head word, valid when fifo_empty=0.
REQ-011 Port fifo_rdreq  out  1: FIFO pop request.
REQ-012 Port avl_ready  in  1: DDR controller accepts the current beat.
REQ-013 Port avl_write_req  out  1: write beat valid.
REQ-014 Port avl_burstbegin  out  1: first beat of a burst.
REQ-015 Port avl_addr  out  ADDR_W: burst start word address.
REQ-016 Port avl_size  out  7: burst length in beats.
REQ-017 Port avl_wdata  out  32: beat data.
REQ-018 Port wr_ptr  out  ADDR_W: address one past the last fully written burst.
REQ-019 Port wrapped  out  1: sticky flag, set when the region has been wrapped at least once.
REQ-020 Port busy  out  1: FSM is not IDLE.

Function
REQ-021 The FSM SHALL have states IDLE, ARM, BURST and FLUSH.
REQ-022 IDLE SHALL go to ARM when cap_en=1 and fifo_usedw>=BURST_LEN.
REQ-023 IDLE SHALL go to FLUSH when cap_en=0 and fifo_empty=0.
REQ-024 ARM SHALL latch avl_addr=cur_addr and avl_size=BURST_LEN, then go to BURST after 1 cycle.
REQ-025 FLUSH SHALL latch avl_size=min(fifo_usedw,BURST_LEN) and then behave like BURST.
REQ-026 In BURST/FLUSH, avl_write_req SHALL be 1 and avl_wdata SHALL equal fifo_q combinationally.
REQ-027 fifo_rdreq SHALL equal avl_write_req & avl_ready; there is no bubble between beats.
REQ-028 avl_burstbegin SHALL be 1 only on the first beat, held until that beat is accepted.
REQ-029 avl_addr and avl_size SHALL be held stable for the whole burst.
REQ-030 The beat counter SHALL increment on each accepted beat; the burst ends on acceptance of beat avl_size.
REQ-031 At burst end, cur_addr SHALL advance by avl_size and wr_ptr SHALL take the new cur_addr in the same cycle.
REQ-032 Wrap: if cur_addr+avl_size >= BASE_ADDR+REGION_WORDS, cur_addr SHALL become BASE_ADDR and wrapped SHALL be set.
REQ-033 After burst end, the FSM SHALL go to IDLE and SHALL NOT start a new burst in that same cycle; minimum gap is 1 cycle.
REQ-034 A change of cap_en mid-burst SHALL NOT abort the burst; it is sampled only in IDLE.
REQ-035 A rising edge of cap_en (from 0 to 1) seen in IDLE SHALL reset cur_addr and wr_ptr to BASE_ADDR and clear wrapped.
REQ-036 If fifo_empty=1 during a burst (underflow), avl_write_req SHALL drop until data reappears; the beat count SHALL be unaffected.

Reset
REQ-037 On reset_ayn=1, the block SHALL asynchronously set state=IDLE, cur_addr=wr_ptr=BASE_ADDR and wrapped=0.
REQ-038 On reset_ayn=1, all Avalon outputs and fifo_rdreq SHALL be 0, and avl_addr/avl_size SHALL be 0.
REQ-039 A reset mid-burst SHALL abandon the burst; the DDR controller is reset by the same source.

Configuration
REQ-040 With AD_DDR_WR_STATS_EN defined, the block SHALL add output burst_cnt [31:0], counting completed bursts, cleared by reset and by cap_en rise, and saturating at all-ones.
REQ-041 With AD_DDR_WR_STATS_EN defined, the block SHALL add output underflow_cnt [15:0], counting cycles spent in REQ-036, saturating.
REQ-042 Without AD_DDR_WR_STATS_EN, these ports and their counters SHALL be absent.

Structure
REQ-043 Package ad_ddr_pkg SHALL hold the FSM state enum, the AVL_SIZE_W=7 constant and the data width constant 32.
REQ-044 Sub-module ad_ddr_addr_gen SHALL contain cur_addr, the wrap logic and the wrapped flag; all other logic stays flat.

Verification
REQ-045 Bench SHALL check: usedw=16, cap_en=1, ready always 1 -> ARM then 16 beats addr=0 size=16, burstbegin on beat 1 only, wr_ptr=16.
REQ-046 Bench SHALL check: ready toggling 1/0 every cycle -> 16 beats over 31 cycles, data in FIFO order, wdata/addr stable while ready=0.
REQ-047 Bench SHALL check: REGION_WORDS=64, 5 bursts -> addresses 0,16,32,48,0; wrapped=1 after the 4th burst.
REQ-048 Bench SHALL check: cap_en falls with usedw=5 -> FLUSH burst size=5, then IDLE with fifo_empty=1.
REQ-049 Bench SHALL check: reset_ayn pulse on beat 7 -> outputs 0 immediately; after release, a new burst starts at BASE_ADDR.
REQ-050 Bench SHALL check: fifo_empty=1 for 3 cycles mid-burst -> write_req low for 3 cycles; the burst still totals 16 beats; underflow_cnt=3 with the macro defined.

Source files
------------

// File: rtl/ad_ddr_pkg.sv
// Shared types and constants for the DDR capture write scheduler.
package ad_ddr_pkg;

    localparam int AVL_SIZE_W = 7;
    localparam int DATA_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_BURST,
        ST_FLUSH
    } state_t;

endpackage

// File: rtl/ad_ddr_addr_gen.sv
// Capture-region address generator: current burst address, region wrap and sticky wrapped flag.
module ad_ddr_addr_gen
    import ad_ddr_pkg::*;
#(
    parameter int ADDR_W       = 25,
    parameter int BASE_ADDR    = 0,
    parameter int REGION_WORDS = 1 << 20
) (
    input  logic                  ddr_clk,
    input  logic                  reset_ayn,
    input  logic                  restart,
    input  logic                  advance,
    input  logic [AVL_SIZE_W-1:0] size,
    output logic [ADDR_W-1:0]     cur_addr,
    output logic                  wrapped
);

    // One extra bit so a region ending exactly at the top of the address space still compares correctly.
    localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(BASE_ADDR + REGION_WORDS);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    logic [ADDR_W:0] next_sum;

    assign next_sum = {1'b0, cur_addr} + (ADDR_W+1)'(size);

    always_ff @(posedge ddr_clk or posedge reset_ayn) begin
        if (reset_ayn) begin
            cur_addr <= BASE;
            wrapped  <= 1'b0;
        end else if (restart) begin
            cur_addr <= BASE;
            wrapped  <= 1'b0;
        end else if (advance) begin
            if (next_sum >= LIMIT) begin
                cur_addr <= BASE;
                wrapped  <= 1'b1;
            end else begin
                cur_addr <= next_sum[ADDR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ad_ddr_wr_sched.sv
// Moves sample-FIFO words into a DDR ring buffer as Avalon bursts.
// Optional statistics counters (burst_cnt, underflow_cnt) with AD_DDR_WR_STATS_EN defined.
//
// state    | meaning
// ST_IDLE  | waiting for a full burst of samples, or for leftover data once capture stops
// ST_ARM   | one cycle to latch burst address and full burst size
// ST_BURST | streaming a full-size burst
// ST_FLUSH | streaming a short final burst after capture stopped
module ad_ddr_wr_sched
    import ad_ddr_pkg::*;
#(
    parameter int BURST_LEN    = 16,
    parameter int ADDR_W       = 25,
    parameter int BASE_ADDR    = 0,
    parameter int REGION_WORDS = 1 << 20
) (
    input  logic                  ddr_clk,
    input  logic                  reset_ayn,
    input  logic                  cap_en,
    input  logic [9:0]            fifo_usedw,
    input  logic                  fifo_empty,
    input  logic [DATA_W-1:0]     fifo_q,
    output logic                  fifo_rdreq,
    input  logic                  avl_ready,
    output logic                  avl_write_req,
    output logic                  avl_burstbegin,
    output logic [ADDR_W-1:0]     avl_addr,
    output logic [AVL_SIZE_W-1:0] avl_size,
    output logic [DATA_W-1:0]     avl_wdata,
    output logic [ADDR_W-1:0]     wr_ptr,
    output logic                  wrapped,
    output logic                  busy
`ifdef AD_DDR_WR_STATS_EN
    ,
    output logic [31:0]           burst_cnt,
    output logic [15:0]           underflow_cnt
`endif
);

    localparam logic [AVL_SIZE_W-1:0] BL       = AVL_SIZE_W'(BURST_LEN);
    localparam logic [9:0]            BL_USEDW = 10'(BURST_LEN);

    state_t                  state, state_nxt;
    logic                    cap_en_q;
    logic                    cap_rise;
    logic                    in_burst;
    logic                    beat_acc;
    logic                    burst_done;
    logic [AVL_SIZE_W-1:0]   beat_cnt;
    logic [AVL_SIZE_W-1:0]   flush_size;
    logic [ADDR_W-1:0]       cur_addr;

    // cap_en is only looked at in IDLE, so its edge history is only tracked there too.
    assign cap_rise       = (state == ST_IDLE) && cap_en && !cap_en_q;
    assign in_burst       = (state == ST_BURST) || (state == ST_FLUSH);
    assign avl_write_req  = in_burst && !fifo_empty;
    assign beat_acc       = avl_write_req && avl_ready;
    assign fifo_rdreq     = beat_acc;
    assign avl_burstbegin = avl_write_req && (beat_cnt == '0);
    assign avl_wdata      = in_burst ? fifo_q : '0;
    assign burst_done     = beat_acc && (beat_cnt == avl_size - AVL_SIZE_W'(1));
    assign busy           = (state != ST_IDLE);
    assign wr_ptr         = cur_addr;

    // A non-empty FIFO holds at least one word even if usedw lags behind.
    always_comb begin
        flush_size = BL;
        if (fifo_usedw < BL_USEDW) begin
            flush_size = (fifo_usedw == '0) ? AVL_SIZE_W'(1) : fifo_usedw[AVL_SIZE_W-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cap_en && (fifo_usedw >= BL_USEDW)) begin
                    state_nxt = ST_ARM;
                end else if (!cap_en && !fifo_empty) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_ARM:   state_nxt = ST_BURST;
            ST_BURST,
            ST_FLUSH: begin
                if (burst_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ddr_clk or posedge reset_ayn) begin
        if (reset_ayn) begin
            state    <= ST_IDLE;
            cap_en_q <= 1'b0;
            beat_cnt <= '0;
            avl_addr <= '0;
            avl_size <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE) begin
                cap_en_q <= cap_en;
            end
            if (burst_done) begin
                beat_cnt <= '0;
            end else if (beat_acc) begin
                beat_cnt <= beat_cnt + AVL_SIZE_W'(1);
            end
            if (state == ST_ARM) begin
                avl_addr <= cur_addr;
                avl_size <= BL;
            end else if ((state == ST_IDLE) && (state_nxt == ST_FLUSH)) begin
                avl_addr <= cur_addr;
                avl_size <= flush_size;
            end
        end
    end

    ad_ddr_addr_gen #(
        .ADDR_W       (ADDR_W),
        .BASE_ADDR    (BASE_ADDR),
        .REGION_WORDS (REGION_WORDS)
    ) u_addr_gen (
        .ddr_clk   (ddr_clk),
        .reset_ayn (reset_ayn),
        .restart   (cap_rise),
        .advance   (burst_done),
        .size      (avl_size),
        .cur_addr  (cur_addr),
        .wrapped   (wrapped)
    );

`ifdef AD_DDR_WR_STATS_EN
    always_ff @(posedge ddr_clk or posedge reset_ayn) begin
        if (reset_ayn) begin
            burst_cnt     <= '0;
            underflow_cnt <= '0;
        end else begin
            if (cap_rise) begin
                burst_cnt <= '0;
            end else if (burst_done && (burst_cnt != '1)) begin
                burst_cnt <= burst_cnt + 32'd1;
            end
            if (in_burst && fifo_empty && (underflow_cnt != '1)) begin
                underflow_cnt <= underflow_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ad_ddr_wr_sched.sv
// Directed bench for ad_ddr_wr_sched: FIFO model, data/burst scoreboard, immediate-assertion checks.
module tb_ad_ddr_wr_sched;

    logic        ddr_clk = 1'b0;
    logic        reset_ayn = 1'b0;
    logic        cap_en = 1'b0;
    logic [9:0]  fifo_usedw = '0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_q = '0;
    logic        fifo_rdreq;
    logic        avl_ready = 1'b1;
    logic        avl_write_req;
    logic        avl_burstbegin;
    logic [24:0] avl_addr;
    logic [6:0]  avl_size;
    logic [31:0] avl_wdata;
    logic [24:0] wr_ptr;
    logic        wrapped;
    logic        busy;
`ifdef AD_DDR_WR_STATS_EN
    logic [31:0] burst_cnt;
    logic [15:0] underflow_cnt;
`endif

    ad_ddr_wr_sched #(
        .BURST_LEN    (16),
        .ADDR_W       (25),
        .BASE_ADDR    (0),
        .REGION_WORDS (64)
    ) dut (
        .ddr_clk        (ddr_clk),
        .reset_ayn      (reset_ayn),
        .cap_en         (cap_en),
        .fifo_usedw     (fifo_usedw),
        .fifo_empty     (fifo_empty),
        .fifo_q         (fifo_q),
        .fifo_rdreq     (fifo_rdreq),
        .avl_ready      (avl_ready),
        .avl_write_req  (avl_write_req),
        .avl_burstbegin (avl_burstbegin),
        .avl_addr       (avl_addr),
        .avl_size       (avl_size),
        .avl_wdata      (avl_wdata),
        .wr_ptr         (wr_ptr),
        .wrapped        (wrapped),
        .busy           (busy)
`ifdef AD_DDR_WR_STATS_EN
        ,
        .burst_cnt      (burst_cnt),
        .underflow_cnt  (underflow_cnt)
`endif
    );

    always #5 ddr_clk = ~ddr_clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] fifo[$];
    logic [31:0] exp_data[$];
    int          exp_addr_q[$];
    int          exp_size_q[$];
    int          cur_exp_addr = 0;
    int          cur_exp_size = 0;
    int          beat_idx = 0;
    int          bursts_done = 0;
    int          cyc = 0;
    int          first_acc = 0;
    int          last_acc = 0;
    int          gap_cnt = 0;
    int          starve = 0;
    bit          ready_toggle = 1'b0;
    bit          stall_prev = 1'b0;
    logic [31:0] stall_wdata = '0;
    logic [24:0] stall_addr = '0;
    logic [31:0] word_seq = 32'hC0DE_0000;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        fifo_usedw = 10'(fifo.size());
        fifo_empty = (fifo.size() == 0) || (starve > 0);
        fifo_q     = (fifo.size() != 0) ? fifo[0] : 32'h0;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            fifo.push_back(word_seq);
            exp_data.push_back(word_seq);
            word_seq = word_seq + 32'h0000_0101;
        end
        drive();
    endtask

    task automatic expect_burst(input int addr, input int size);
        exp_addr_q.push_back(addr);
        exp_size_q.push_back(size);
    endtask

    // One clock: sample at the falling edge, score accepted beats, then update the FIFO model after the rising edge.
    task automatic tick();
        logic        pop;
        logic [31:0] w;
        @(negedge ddr_clk);
        cyc++;
        if (stall_prev) begin
            chk("stall_wdata", avl_wdata, stall_wdata);
            chk("stall_addr", avl_addr, stall_addr);
        end
        stall_prev  = avl_write_req && !avl_ready;
        stall_wdata = avl_wdata;
        stall_addr  = avl_addr;
        if (busy && !avl_write_req && beat_idx > 0) gap_cnt++;
        if (avl_write_req && avl_ready) begin
            if (beat_idx == 0) begin
                cur_exp_addr = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : -1;
                cur_exp_size = (exp_size_q.size() != 0) ? exp_size_q.pop_front() : -1;
                first_acc    = cyc;
            end
            chk("burstbegin", avl_burstbegin, beat_idx == 0);
            chk("addr", avl_addr, cur_exp_addr);
            chk("size", avl_size, cur_exp_size);
            w = (exp_data.size() != 0) ? exp_data.pop_front() : 32'hxxxx_xxxx;
            chk("wdata", avl_wdata, w);
            beat_idx++;
            if (beat_idx == cur_exp_size) begin
                beat_idx = 0;
                bursts_done++;
                last_acc = cyc;
            end
        end
        pop = fifo_rdreq;
        @(posedge ddr_clk);
        #1;
        if (pop && fifo.size() != 0) void'(fifo.pop_front());
        if (starve > 0) starve--;
        if (ready_toggle) avl_ready = !avl_ready;
        drive();
    endtask

    task automatic wait_burst(input int target);
        int t = 0;
        while (bursts_done < target && t < 300) begin
            tick();
            t++;
        end
        chk("burst_timeout", bursts_done, target);
    endtask

    task automatic wait_beats(input int n);
        int t = 0;
        while (beat_idx < n && t < 100) begin
            tick();
            t++;
        end
        chk("beat_timeout", beat_idx, n);
    endtask

    initial begin
        // Reset state
        #1 reset_ayn = 1'b1;
        #1;
        chk("rst_write_req", avl_write_req, 0);
        chk("rst_burstbegin", avl_burstbegin, 0);
        chk("rst_rdreq", fifo_rdreq, 0);
        chk("rst_addr", avl_addr, 0);
        chk("rst_size", avl_size, 0);
        chk("rst_wr_ptr", wr_ptr, 0);
        chk("rst_wrapped", wrapped, 0);
        chk("rst_busy", busy, 0);
        @(negedge ddr_clk);
        reset_ayn = 1'b0;
        @(posedge ddr_clk);
        #1;

        // Full burst, ready always high
        expect_burst(0, 16);
        push_words(16);
        cap_en = 1'b1;
        tick();
        chk("a_arm_busy", busy, 1);
        chk("a_arm_write_req", avl_write_req, 0);
        wait_burst(1);
        chk("a_span", last_acc - first_acc, 15);
        chk("a_gap_busy", busy, 0);
        chk("a_wr_ptr", wr_ptr, 16);

        // Ready toggling every cycle
        ready_toggle = 1'b1;
        expect_burst(16, 16);
        push_words(16);
        wait_burst(2);
        chk("b_span", last_acc - first_acc, 30);
        chk("b_wr_ptr", wr_ptr, 32);
        ready_toggle = 1'b0;
        avl_ready = 1'b1;
        stall_prev = 1'b0;

        // Region wrap: restart capture, five back-to-back bursts
        cap_en = 1'b0;
        tick();
        tick();
        cap_en = 1'b1;
        expect_burst(0, 16);
        expect_burst(16, 16);
        expect_burst(32, 16);
        expect_burst(48, 16);
        expect_burst(0, 16);
        push_words(80);
        for (int k = 1; k <= 5; k++) begin
            wait_burst(2 + k);
            chk("c_gap_busy", busy, 0);
            chk("c_wr_ptr", wr_ptr, (k % 4) * 16);
            chk("c_wrapped", wrapped, k >= 4);
        end

        // Flush of a short tail after capture stops
        push_words(5);
        tick();
        tick();
        chk("d_hold_idle", busy, 0);
        cap_en = 1'b0;
        expect_burst(16, 5);
        tick();
        chk("d_flush_busy", busy, 1);
        chk("d_flush_size", avl_size, 5);
        chk("d_flush_addr", avl_addr, 16);
        wait_burst(8);
        chk("d_idle", busy, 0);
        chk("d_fifo_left", fifo.size(), 0);
        chk("d_fifo_empty", fifo_empty, 1);
        chk("d_wr_ptr", wr_ptr, 21);

        // Reset in the middle of a burst, on beat 7
        cap_en = 1'b1;
        expect_burst(0, 16);
        push_words(16);
        wait_beats(6);
        #2;
        chk("e_pre_write_req", avl_write_req, 1);
        reset_ayn = 1'b1;
        #1;
        chk("e_rst_write_req", avl_write_req, 0);
        chk("e_rst_rdreq", fifo_rdreq, 0);
        chk("e_rst_burstbegin", avl_burstbegin, 0);
        chk("e_rst_addr", avl_addr, 0);
        chk("e_rst_size", avl_size, 0);
        chk("e_rst_wdata", avl_wdata, 0);
        chk("e_rst_busy", busy, 0);
        fifo.delete();
        exp_data.delete();
        exp_addr_q.delete();
        exp_size_q.delete();
        beat_idx = 0;
        stall_prev = 1'b0;
        @(negedge ddr_clk);
        reset_ayn = 1'b0;
        @(posedge ddr_clk);
        #1;
        expect_burst(0, 16);
        push_words(16);
        wait_burst(9);
        chk("e_wr_ptr", wr_ptr, 16);

        // FIFO underflow for three cycles mid-burst
        gap_cnt = 0;
        expect_burst(16, 16);
        push_words(16);
        wait_beats(4);
        starve = 3;
        drive();
        wait_burst(10);
        chk("f_gap_cycles", gap_cnt, 3);
        chk("f_wr_ptr", wr_ptr, 32);
        chk("f_idle", busy, 0);
`ifdef AD_DDR_WR_STATS_EN
        chk("f_underflow_cnt", underflow_cnt, 3);
        chk("f_burst_cnt", burst_cnt, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
